// File: rtl/pwm_cfg_pkg.sv
// Shared register map and ramp state encoding for the PWM configuration sequencer.
package pwm_cfg_pkg;

  localparam int unsigned EN_LO   = 0;
  localparam int unsigned EN_HI   = 1;
  localparam int unsigned MODE_LO = 2;
  localparam int unsigned MODE_HI = 3;
  localparam int unsigned DUTY    = 4;

  typedef enum logic [1:0] {
    RAMP_OFF  = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/pwm_cfg_sequencer_ramp_gen.sv
// Triangle-wave duty ramp: tick divider, up/down FSM, duty shadow and a
// coalescing pending-write flag that the arbiter grants or cancels.
module pwm_ramp_gen
  import pwm_cfg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STEP   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ramp_en_i,
  input  logic [7:0]        ramp_div_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              grant_i,
  output logic              pend_now_o,
  output logic [DATA_W-1:0] duty_next_o,
  output logic [DATA_W-1:0] duty_o
);

  localparam logic [DATA_W-1:0] D_MAX  = '1;
  localparam logic [DATA_W-1:0] D_STEP = DATA_W'(STEP);

  ramp_state_e       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        div_q, div_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              pend_q, pend_d;
  logic [DATA_W:0]   stepped;

  // MSB of the result flags a direction reversal at either end of the range.
  function automatic logic [DATA_W:0] step_duty(input logic up, input logic [DATA_W-1:0] d);
    if (up) begin
      if (d >= D_MAX - D_STEP) step_duty = {1'b1, D_MAX};
      else                     step_duty = {1'b0, d + D_STEP};
    end else begin
      if (d <= D_STEP) step_duty = {1'b1, {DATA_W{1'b0}}};
      else             step_duty = {1'b0, d - D_STEP};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    duty_d  = duty_q;
    pend_d  = pend_q;
    stepped = '0;
    if (!ramp_en_i) begin
      state_d = RAMP_OFF;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (state_q == RAMP_OFF) begin
      state_d = RAMP_UP;
      cnt_d   = '0;
      div_d   = ramp_div_i;
      pend_d  = 1'b0;
    end else if (load_i) begin
      // SPI duty override: restart the period and drop any stale ramp value.
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_d   = '0;
      div_d   = ramp_div_i;
      stepped = step_duty(state_q == RAMP_UP, duty_q);
      duty_d  = stepped[DATA_W-1:0];
      pend_d  = 1'b1;
      if (stepped[DATA_W]) state_d = (state_q == RAMP_UP) ? RAMP_DOWN : RAMP_UP;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    if (load_i) duty_d = load_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RAMP_OFF;
      cnt_q   <= '0;
      div_q   <= '0;
      duty_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      duty_q  <= duty_d;
      pend_q  <= pend_d & ~grant_i;
    end
  end

  assign pend_now_o  = pend_d;
  assign duty_next_o = duty_d;
  assign duty_o      = duty_q;

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Sole writer of the PWM register bank: SPI writes take priority over the duty
// ramp, with a starvation guard that periodically forces a ramp write through.
module pwm_cfg_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int MAX_ADDR   = int'(DUTY),
  parameter int DUTY_ADDR  = int'(DUTY),
  parameter int STEP       = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_valid,
  output logic              spi_ready,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_data,
  input  logic              ramp_en,
  input  logic [7:0]        ramp_div,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] duty_shadow,
  output logic [7:0]        bad_addr_cnt
);

  logic              spi_xfer, addr_ok, duty_load;
  logic              ramp_pend, ramp_grant;
  logic [DATA_W-1:0] duty_next, duty_cur;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [7:0]        bad_q, bad_d;
  logic [7:0]        starve_q, starve_d;
  logic              rdy_q, rdy_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign spi_xfer   = spi_valid & rdy_q;
  assign addr_ok    = (spi_addr <= ADDR_W'(MAX_ADDR));
  assign duty_load  = spi_xfer & addr_ok & (spi_addr == ADDR_W'(DUTY_ADDR));
  assign ramp_grant = ramp_pend & ~spi_xfer;

  pwm_ramp_gen #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) u_ramp (
    .clk_i       (clk),
    .rst_i       (rst),
    .ramp_en_i   (ramp_en),
    .ramp_div_i  (ramp_div),
    .load_i      (duty_load),
    .load_data_i (spi_data),
    .grant_i     (ramp_grant),
    .pend_now_o  (ramp_pend),
    .duty_next_o (duty_next),
    .duty_o      (duty_cur)
  );

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bad_d     = bad_q;
    starve_d  = starve_q;
    rdy_d     = 1'b1;
    if (spi_xfer) begin
      if (addr_ok) begin
        wr_en_d   = 1'b1;
        wr_addr_d = spi_addr;
        wr_data_d = spi_data;
      end else begin
        bad_d = sat_inc(bad_q);
      end
    end else if (ramp_grant) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ADDR_W'(DUTY_ADDR);
      wr_data_d = duty_next;
    end
    // A pending ramp write that lost to SPI ages; at the limit SPI is held off one cycle.
    if (!ramp_pend || ramp_grant) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q + 8'd1;
      rdy_d    = (starve_d != 8'(STARVE_MAX));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      bad_q     <= '0;
      starve_q  <= '0;
      rdy_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      bad_q     <= bad_d;
      starve_q  <= starve_d;
      rdy_q     <= rdy_d;
    end
  end

  assign spi_ready    = rdy_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign duty_shadow  = duty_cur;
  assign bad_addr_cnt = bad_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer: vector tables plus hand-timed
// sequences for ramp sweep, starvation guard and mid-operation reset.
module tb_pwm_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_valid;
  logic       spi_ready;
  logic [6:0] spi_addr;
  logic [7:0] spi_data;
  logic       ramp_en;
  logic [7:0] ramp_div;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] duty_shadow;
  logic [7:0] bad_addr_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic       sv;
    logic [6:0] sa;
    logic [7:0] sd;
    logic       en;
    logic       ewr;
    logic [6:0] ea;
    logic [7:0] ed;
    logic [7:0] eduty;
    logic [7:0] ebad;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  pwm_cfg_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .spi_valid    (spi_valid),
    .spi_ready    (spi_ready),
    .spi_addr     (spi_addr),
    .spi_data     (spi_data),
    .ramp_en      (ramp_en),
    .ramp_div     (ramp_div),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .duty_shadow  (duty_shadow),
    .bad_addr_cnt (bad_addr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time bound expired, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int sv, input int sa, input int sd, input int en,
                              input int ewr, input int ea, input int ed,
                              input int eduty, input int ebad);
    vec_t v;
    v.sv = sv[0]; v.sa = sa[6:0]; v.sd = sd[7:0]; v.en = en[0];
    v.ewr = ewr[0]; v.ea = ea[6:0]; v.ed = ed[7:0];
    v.eduty = eduty[7:0]; v.ebad = ebad[7:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name, input int idx);
    spi_valid = v.sv;
    spi_addr  = v.sa;
    spi_data  = v.sd;
    ramp_en   = v.en;
    @(posedge clk);
    #1;
    n_vec++;
    if (wr_en !== v.ewr || (v.ewr && (wr_addr !== v.ea || wr_data !== v.ed)) ||
        duty_shadow !== v.eduty || bad_addr_cnt !== v.ebad || spi_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL %s[%0d]: got wr_en=%0b addr=%h data=%h duty=%h bad=%0d rdy=%0b; required wr_en=%0b addr=%h data=%h duty=%h bad=%0d rdy=1",
               name, idx, wr_en, wr_addr, wr_data, duty_shadow, bad_addr_cnt, spi_ready,
               v.ewr, v.ea, v.ed, v.eduty, v.ebad);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    spi_valid = 1'b0; spi_addr = '0; spi_data = '0;
    ramp_en = 1'b0; ramp_div = 8'd3;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int   k, last, expv;
    logic saw_wr;

    // basic SPI path and bad-address counting, ramp off
    tab_a.push_back(mk(0, 'h00, 'h00, 0, 0, 'h00, 'h00, 'h00, 0));
    tab_a.push_back(mk(1, 'h02, 'hA5, 0, 1, 'h02, 'hA5, 'h00, 0));
    tab_a.push_back(mk(0, 'h00, 'h00, 0, 0, 'h00, 'h00, 'h00, 0));
    tab_a.push_back(mk(1, 'h05, 'h11, 0, 0, 'h00, 'h00, 'h00, 1));
    tab_a.push_back(mk(1, 'h7F, 'h22, 0, 0, 'h00, 'h00, 'h00, 2));
    tab_a.push_back(mk(1, 'h00, 'h3C, 0, 1, 'h00, 'h3C, 'h00, 2));
    tab_a.push_back(mk(1, 'h04, 'h80, 0, 1, 'h04, 'h80, 'h80, 2));
    tab_a.push_back(mk(1, 'h03, 'hFF, 0, 1, 'h03, 'hFF, 'h80, 2));
    tab_a.push_back(mk(1, 'h01, 'h01, 0, 1, 'h01, 'h01, 'h80, 2));
    tab_a.push_back(mk(0, 'h00, 'h00, 0, 0, 'h00, 'h00, 'h80, 2));

    // duty override during ramp (ramp_div=3), ending with a pending ramp write
    tab_b.push_back(mk(0, 'h00, 'h00, 0, 0, 'h00, 'h00, 'h00, 0));
    tab_b.push_back(mk(1, 'h04, 'h3F, 0, 1, 'h04, 'h3F, 'h3F, 0));
    for (int i = 0; i < 4; i++) tab_b.push_back(mk(0, 0, 0, 1, 0, 0, 0, 'h3F, 0));
    tab_b.push_back(mk(0, 'h00, 'h00, 1, 1, 'h04, 'h40, 'h40, 0));
    for (int i = 0; i < 3; i++) tab_b.push_back(mk(0, 0, 0, 1, 0, 0, 0, 'h40, 0));
    tab_b.push_back(mk(1, 'h01, 'h77, 1, 1, 'h01, 'h77, 'h41, 0));
    tab_b.push_back(mk(1, 'h04, 'h10, 1, 1, 'h04, 'h10, 'h10, 0));
    for (int i = 0; i < 3; i++) tab_b.push_back(mk(0, 0, 0, 1, 0, 0, 0, 'h10, 0));
    tab_b.push_back(mk(0, 'h00, 'h00, 1, 1, 'h04, 'h11, 'h11, 0));
    for (int i = 0; i < 3; i++) tab_b.push_back(mk(0, 0, 0, 1, 0, 0, 0, 'h11, 0));
    tab_b.push_back(mk(1, 'h02, 'h55, 1, 1, 'h02, 'h55, 'h12, 0));

    // reset state
    rst = 1'b1;
    spi_valid = 1'b0; spi_addr = '0; spi_data = '0;
    ramp_en = 1'b0; ramp_div = 8'd3;
    @(posedge clk);
    #1;
    check("reset_outputs", {wr_en, wr_addr, wr_data, duty_shadow, bad_addr_cnt, spi_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("reset_ready_low", {63'd0, spi_ready}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < tab_a.size(); i++) apply(tab_a[i], "spi_vec", i);

    // bad address saturation
    saw_wr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      spi_valid = 1'b1;
      spi_addr  = 7'(5 + (i % 120));
      spi_data  = 8'(i);
      @(posedge clk);
      #1;
      if (wr_en) saw_wr = 1'b1;
      if (i == 100) check("bad_cnt_mid", {56'd0, bad_addr_cnt}, 64'd103);
    end
    spi_valid = 1'b0;
    check("bad_cnt_sat", {56'd0, bad_addr_cnt}, 64'd255);
    check("bad_no_strobe", {63'd0, saw_wr}, 64'd0);

    // duty override table, then asynchronous reset with a ramp write pending
    do_reset();
    for (int i = 0; i < tab_b.size(); i++) apply(tab_b[i], "ovr_vec", i);
    rst = 1'b1;
    spi_valid = 1'b0;
    #1;
    check("async_reset", {wr_en, wr_addr, wr_data, duty_shadow, bad_addr_cnt, spi_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      @(posedge clk);
      #1;
      if (s < 5) check("post_reset_quiet", {63'd0, wr_en}, 64'd0);
      else       check("post_reset_tick", {48'd0, wr_en, wr_addr, wr_data}, {48'd0, 1'b1, 7'h04, 8'h01});
    end

    // full triangle sweep, ramp_div=3, no SPI traffic
    do_reset();
    ramp_en = 1'b1;
    k = 0;
    last = 1;
    for (int cyc = 1; cyc <= 4 * 515 + 20 && k < 512; cyc++) begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        k++;
        expv = (k <= 255) ? k : (k <= 510) ? 510 - k : k - 510;
        check("ramp_write", {40'd0, wr_addr, wr_data, duty_shadow, 1'b0},
              {40'd0, 7'h04, 8'(expv), 8'(expv), 1'b0});
        check("ramp_interval", 64'(cyc), 64'(last + 4));
        last = cyc;
      end
    end
    check("ramp_write_count", 64'(k), 64'd512);

    // starvation guard, ramp_div=0, SPI held busy with a valid non-duty address
    rst = 1'b1;
    ramp_en = 1'b1; ramp_div = 8'd0;
    spi_valid = 1'b1; spi_addr = 7'h02; spi_data = 8'h33;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 1; s <= 11; s++) begin
      logic       e_rdy, e_wr, e_ramp;
      logic [6:0] e_a;
      logic [7:0] e_d;
      @(posedge clk);
      #1;
      e_rdy  = !(s == 5 || s == 10);
      e_wr   = (s != 1);
      e_ramp = (s == 6 || s == 11);
      e_a    = e_ramp ? 7'h04 : (e_wr ? 7'h02 : wr_addr);
      e_d    = e_ramp ? ((s == 6) ? 8'd5 : 8'd10) : (e_wr ? 8'h33 : wr_data);
      check($sformatf("starve_s%0d", s), {47'd0, spi_ready, wr_en, wr_addr, wr_data},
            {47'd0, e_rdy, e_wr, e_a, e_d});
      if (e_ramp) check($sformatf("starve_duty_s%0d", s), {56'd0, duty_shadow}, {56'd0, e_d});
    end
    spi_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
